// File: rtl/multififo_pkg.sv
// Shared constants and pointer-wrap helper for the multififo family.
package multififo_pkg;

   localparam int unsigned MAXLANES = 8;
   localparam int unsigned LANEW    = 4;
   localparam int unsigned COUNTW   = 16;

   // Compare-and-subtract wrap; valid for ptr < depth and inc <= depth, any depth.
   function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
      int unsigned sum;
      sum = ptr + inc;
      if (sum >= depth) sum = sum - depth;
      return sum;
   endfunction

endpackage

// File: rtl/multififo_outreg.sv
// Registered single-word output stage with valid/ready handshake and pop generation.
module multififo_outreg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             softreset,
   input  logic             nonempty,
   input  logic [WIDTH-1:0] head,
   output logic             pop_c,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   input  logic             dout_rdy
);

   // Refill the output register whenever it is empty or being consumed.
   assign pop_c = !softreset && nonempty && (!dout_vld || dout_rdy);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout     <= '0;
         dout_vld <= 1'b0;
      end else if (softreset) begin
         dout_vld <= 1'b0;
      end else if (pop_c) begin
         dout     <= head;
         dout_vld <= 1'b1;
      end else if (dout_rdy) begin
         dout_vld <= 1'b0;
      end
   end

endmodule

// File: rtl/multififo_w8_r1.sv
// 8-lane-in / 1-word-out FIFO: all-or-nothing multi-word admission, registered single-word drain.
module multififo_w8_r1
   import multififo_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      softreset,
   input  logic [LANEW-1:0]          writes,
   input  logic [WIDTH*MAXLANES-1:0] din,
   output logic                      taken,
   output logic [WIDTH-1:0]          dout,
   output logic                      dout_vld,
   input  logic                      dout_rdy,
   output logic [COUNTW-1:0]         count,
   output logic [COUNTW-1:0]         frees,
   output logic                      err_badwrite
);

   localparam int unsigned WIDPTR = $clog2(DEPTH);
   localparam int unsigned PTRW   = WIDPTR + 1;

   logic [WIDTH-1:0]  fifos [DEPTH];
   logic [PTRW-1:0]   wptr;
   logic [PTRW-1:0]   rptr;
   logic              badwrite;
   logic              pop;
   logic              nonempty;
   logic [COUNTW:0]   fill_sum;
   logic [COUNTW-1:0] count_nxt;
   logic [WIDTH-1:0]  head;

   // Admission uses the pre-pop count at full width so no wrap can fake room.
   assign badwrite = writes > LANEW'(MAXLANES);
   assign fill_sum = (COUNTW+1)'(count) + (COUNTW+1)'(writes);
   assign taken    = !softreset && !badwrite && (fill_sum <= (COUNTW+1)'(DEPTH));
   assign nonempty = (count != '0);
   assign head     = fifos[WIDPTR'(rptr)];

   always_comb begin
      count_nxt = count;
      if (taken) count_nxt = count_nxt + COUNTW'(writes);
      if (pop)   count_nxt = count_nxt - COUNTW'(1);
   end

   // Lane scatter: lane k lands at wptr+k, wrapped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) fifos[i] <= '0;
      end else if (taken) begin
         for (int unsigned k = 0; k < MAXLANES; k++) begin
            if (LANEW'(k) < writes)
               fifos[WIDPTR'(ptr_wrap(32'(wptr), k, DEPTH))] <= din[WIDTH*k +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         frees        <= COUNTW'(DEPTH);
         err_badwrite <= 1'b0;
      end else if (softreset) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         frees        <= COUNTW'(DEPTH);
         err_badwrite <= 1'b0;
      end else begin
         if (taken) wptr <= PTRW'(ptr_wrap(32'(wptr), 32'(writes), DEPTH));
         if (pop)   rptr <= PTRW'(ptr_wrap(32'(rptr), 1, DEPTH));
         count <= count_nxt;
         frees <= COUNTW'(DEPTH) - count_nxt;
         if (badwrite) err_badwrite <= 1'b1;
      end
   end

   multififo_outreg #(
      .WIDTH(WIDTH)
   ) u_outreg (
      .clk      (clk),
      .rst      (rst),
      .softreset(softreset),
      .nonempty (nonempty),
      .head     (head),
      .pop_c    (pop),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy)
   );

endmodule

// File: tb/tb_multififo_w8_r1.sv
// Bench for multififo_w8_r1: directed scenarios on DEPTH=16, randomized queue-model run on DEPTH=16 and DEPTH=12.
module tb_multififo_w8_r1;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           softreset = 1'b0;
   logic           dout_rdy = 1'b0;
   logic [3:0]     writes = '0;
   logic [W*8-1:0] din = '0;

   logic           taken_a, dout_vld_a, err_a;
   logic [W-1:0]   dout_a;
   logic [15:0]    count_a, frees_a;
   logic           taken_b, dout_vld_b, err_b;
   logic [W-1:0]   dout_b;
   logic [15:0]    count_b, frees_b;

   int checks = 0;
   int errors = 0;

   // Reference model: one word queue plus output-register image per instance.
   logic [W-1:0]   mq [2][$];
   logic           mov [2];
   logic [W-1:0]   mod [2];
   logic           merr [2];
   int unsigned    mdep [2];

   always #5 clk = ~clk;

   multififo_w8_r1 #(.WIDTH(W), .DEPTH(16)) dut_a (
      .clk(clk), .rst(rst), .softreset(softreset), .writes(writes), .din(din),
      .taken(taken_a), .dout(dout_a), .dout_vld(dout_vld_a), .dout_rdy(dout_rdy),
      .count(count_a), .frees(frees_a), .err_badwrite(err_a));

   multififo_w8_r1 #(.WIDTH(W), .DEPTH(12)) dut_b (
      .clk(clk), .rst(rst), .softreset(softreset), .writes(writes), .din(din),
      .taken(taken_b), .dout(dout_b), .dout_vld(dout_vld_b), .dout_rdy(dout_rdy),
      .count(count_b), .frees(frees_b), .err_badwrite(err_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lanes(input logic [W-1:0] base);
      din = '0;
      for (int k = 0; k < 8; k++) din[W*k +: W] = base + W'(k);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (count_a !== 16'd0 || frees_a !== 16'd16 || dout_vld_a !== 1'b0 ||
          dout_a !== '0 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL reset count=%0d frees=%0d vld=%b dout=%0h err=%b exp 0/16/0/0/0",
                  count_a, frees_a, dout_vld_a, dout_a, err_a);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single_lane();
      writes = 4'd1; din = '0; din[W-1:0] = 32'hA1; dout_rdy = 1'b1;
      #1;
      checks++;
      if (taken_a !== 1'b1) begin errors++; $display("FAIL single_taken got %b exp 1", taken_a); end
      tick();
      writes = 4'd0;
      checks++;
      if (count_a !== 16'd1 || dout_vld_a !== 1'b0) begin
         errors++; $display("FAIL single_stage1 count=%0d vld=%b exp 1/0", count_a, dout_vld_a);
      end
      tick();
      checks++;
      if (dout_a !== 32'hA1 || dout_vld_a !== 1'b1 || count_a !== 16'd0) begin
         errors++;
         $display("FAIL single_out dout=%0h vld=%b count=%0d exp a1/1/0", dout_a, dout_vld_a, count_a);
      end
      tick();
      checks++;
      if (dout_vld_a !== 1'b0 || dout_a !== 32'hA1) begin
         errors++; $display("FAIL single_drop vld=%b dout=%0h exp 0/a1", dout_vld_a, dout_a);
      end
   endtask

   task automatic test_burst();
      logic [W-1:0] exp_seq [17];
      for (int j = 0; j < 8; j++) begin
         exp_seq[j]     = 32'h10 + W'(j);
         exp_seq[j + 8] = 32'h10 + W'(j);
      end
      exp_seq[16] = 32'hEE;
      dout_rdy = 1'b0;
      writes = 4'd8; set_lanes(32'h10);
      #1;
      checks++;
      if (taken_a !== 1'b1) begin errors++; $display("FAIL burst_taken1 got %b exp 1", taken_a); end
      tick();
      checks++;
      if (taken_a !== 1'b1) begin errors++; $display("FAIL burst_taken2 got %b exp 1", taken_a); end
      tick();
      checks++;
      if (count_a !== 16'd15 || dout_vld_a !== 1'b1) begin
         errors++; $display("FAIL burst_count15 count=%0d vld=%b exp 15/1", count_a, dout_vld_a);
      end
      writes = 4'd1; din = '0; din[W-1:0] = 32'hEE;
      tick();
      checks++;
      if (count_a !== 16'd16 || frees_a !== 16'd0) begin
         errors++; $display("FAIL burst_full count=%0d frees=%0d exp 16/0", count_a, frees_a);
      end
      din[W-1:0] = 32'hFF;
      #1;
      checks++;
      if (taken_a !== 1'b0) begin errors++; $display("FAIL burst_reject got %b exp 0", taken_a); end
      tick();
      writes = 4'd0;
      dout_rdy = 1'b1;
      for (int j = 0; j < 17; j++) begin
         checks++;
         if (dout_a !== exp_seq[j] || dout_vld_a !== 1'b1) begin
            errors++;
            $display("FAIL burst_seq[%0d] dout=%0h vld=%b exp %0h/1", j, dout_a, dout_vld_a, exp_seq[j]);
         end
         tick();
      end
      checks++;
      if (dout_vld_a !== 1'b0 || count_a !== 16'd0) begin
         errors++; $display("FAIL burst_empty vld=%b count=%0d exp 0/0", dout_vld_a, count_a);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      dout_rdy = 1'b0;
      writes = 4'd8; set_lanes(32'h20);
      tick();
      writes = 4'd0;
      tick();
      for (int j = 0; j < 4; j++) begin
         tick();
         checks++;
         if (dout_a !== 32'h20 || dout_vld_a !== 1'b1) begin
            errors++; $display("FAIL bp_stable[%0d] dout=%0h vld=%b exp 20/1", j, dout_a, dout_vld_a);
         end
      end
      writes = 4'd6; set_lanes(32'h30);
      tick();
      checks++;
      if (count_a !== 16'd13) begin errors++; $display("FAIL bp_count13 got %0d exp 13", count_a); end
      writes = 4'd3; set_lanes(32'h40); dout_rdy = 1'b1;
      #1;
      checks++;
      if (taken_a !== 1'b1) begin errors++; $display("FAIL bp_taken got %b exp 1", taken_a); end
      tick();
      checks++;
      if (count_a !== 16'd15) begin errors++; $display("FAIL bp_count15 got %0d exp 15", count_a); end
      writes = 4'd0;
      cyc = 0;
      while ((count_a !== 16'd0 || dout_vld_a !== 1'b0) && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++;
      if (count_a !== 16'd0 || dout_vld_a !== 1'b0) begin
         errors++; $display("FAIL bp_drain timeout count=%0d vld=%b exp 0/0", count_a, dout_vld_a);
      end
   endtask

   task automatic test_badwrite();
      writes = 4'd9; set_lanes(32'h50);
      #1;
      checks++;
      if (taken_a !== 1'b0) begin errors++; $display("FAIL bad_taken got %b exp 0", taken_a); end
      tick();
      checks++;
      if (count_a !== 16'd0 || err_a !== 1'b1) begin
         errors++; $display("FAIL bad_flag count=%0d err=%b exp 0/1", count_a, err_a);
      end
      writes = 4'd2;
      tick();
      checks++;
      if (count_a !== 16'd2 || err_a !== 1'b1) begin
         errors++; $display("FAIL bad_sticky count=%0d err=%b exp 2/1", count_a, err_a);
      end
      writes = 4'd0; softreset = 1'b1;
      tick();
      softreset = 1'b0;
      checks++;
      if (count_a !== 16'd0 || err_a !== 1'b0) begin
         errors++; $display("FAIL bad_clear count=%0d err=%b exp 0/0", count_a, err_a);
      end
   endtask

   task automatic test_softreset();
      dout_rdy = 1'b0;
      writes = 4'd8; set_lanes(32'h60);
      tick();
      writes = 4'd0;
      tick();
      checks++;
      if (count_a !== 16'd7 || dout_vld_a !== 1'b1) begin
         errors++; $display("FAIL sr_pre count=%0d vld=%b exp 7/1", count_a, dout_vld_a);
      end
      softreset = 1'b1; writes = 4'd4;
      #1;
      checks++;
      if (taken_a !== 1'b0) begin errors++; $display("FAIL sr_taken got %b exp 0", taken_a); end
      tick();
      softreset = 1'b0; writes = 4'd0;
      checks++;
      if (count_a !== 16'd0 || dout_vld_a !== 1'b0 || frees_a !== 16'd16) begin
         errors++;
         $display("FAIL sr_flush count=%0d vld=%b frees=%0d exp 0/0/16", count_a, dout_vld_a, frees_a);
      end
   endtask

   task automatic test_async_reset();
      dout_rdy = 1'b0;
      writes = 4'd8; set_lanes(32'h70);
      tick();
      writes = 4'd0;
      tick();
      rst = 1'b1;
      #2;
      checks++;
      if (count_a !== 16'd0 || dout_vld_a !== 1'b0 || dout_a !== '0 ||
          frees_a !== 16'd16 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL async_rst count=%0d vld=%b dout=%0h frees=%0d err=%b exp 0/0/0/16/0",
                  count_a, dout_vld_a, dout_a, frees_a, err_a);
      end
      rst = 1'b0;
      writes = 4'd1; din = '0; din[W-1:0] = 32'h55; dout_rdy = 1'b1;
      #1;
      checks++;
      if (taken_a !== 1'b1) begin errors++; $display("FAIL async_first_taken got %b exp 1", taken_a); end
      tick();
      writes = 4'd0;
      checks++;
      if (count_a !== 16'd1) begin errors++; $display("FAIL async_first_count got %0d exp 1", count_a); end
      tick();
      checks++;
      if (dout_a !== 32'h55 || dout_vld_a !== 1'b1) begin
         errors++; $display("FAIL async_first_out dout=%0h vld=%b exp 55/1", dout_a, dout_vld_a);
      end
   endtask

   task automatic test_random();
      logic         act_taken [2];
      logic         act_vld [2];
      logic [W-1:0] act_dout [2];
      logic [15:0]  act_count [2];
      logic [15:0]  act_frees [2];
      logic         act_err [2];
      logic         exp_taken [2];
      int unsigned  r;
      int unsigned  wr;
      mdep[0] = 16; mdep[1] = 12;
      rst = 1'b1; #1; rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mq[i].delete(); mov[i] = 1'b0; mod[i] = '0; merr[i] = 1'b0;
      end
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         softreset = (r < 3);
         if ($urandom_range(0, 24) == 0)
            writes = 4'($urandom_range(9, 15));
         else if (((n / 100) % 2) == 0 || $urandom_range(0, 2) == 0)
            writes = 4'($urandom_range(0, 8));
         else
            writes = 4'd0;
         for (int k = 0; k < 8; k++) din[W*k +: W] = $urandom;
         dout_rdy = ($urandom_range(0, 9) < 7);
         #1;
         wr = 32'(writes);
         act_taken[0] = taken_a; act_taken[1] = taken_b;
         for (int i = 0; i < 2; i++) begin
            exp_taken[i] = !softreset && (wr <= 8) && (mq[i].size() + wr <= mdep[i]);
            checks++;
            if (act_taken[i] !== exp_taken[i]) begin
               errors++;
               $display("FAIL rnd_taken[%0d] cyc %0d got %b exp %b", i, n, act_taken[i], exp_taken[i]);
            end
            if (softreset) begin
               mq[i].delete(); mov[i] = 1'b0; merr[i] = 1'b0;
            end else begin
               if (mq[i].size() > 0 && (!mov[i] || dout_rdy)) begin
                  mod[i] = mq[i].pop_front();
                  mov[i] = 1'b1;
               end else if (dout_rdy) begin
                  mov[i] = 1'b0;
               end
               if (exp_taken[i])
                  for (int k = 0; k < int'(wr); k++) mq[i].push_back(din[W*k +: W]);
               if (wr > 8) merr[i] = 1'b1;
            end
         end
         tick();
         act_vld[0] = dout_vld_a; act_vld[1] = dout_vld_b;
         act_dout[0] = dout_a;    act_dout[1] = dout_b;
         act_count[0] = count_a;  act_count[1] = count_b;
         act_frees[0] = frees_a;  act_frees[1] = frees_b;
         act_err[0] = err_a;      act_err[1] = err_b;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vld[i] !== mov[i] || act_dout[i] !== mod[i]) begin
               errors++;
               $display("FAIL rnd_out[%0d] cyc %0d got vld=%b dout=%0h exp vld=%b dout=%0h",
                        i, n, act_vld[i], act_dout[i], mov[i], mod[i]);
            end
            checks++;
            if (act_count[i] !== 16'(mq[i].size()) || act_frees[i] !== 16'(mdep[i] - mq[i].size())) begin
               errors++;
               $display("FAIL rnd_count[%0d] cyc %0d got count=%0d frees=%0d exp count=%0d frees=%0d",
                        i, n, act_count[i], act_frees[i], mq[i].size(), mdep[i] - mq[i].size());
            end
            checks++;
            if (act_err[i] !== merr[i]) begin
               errors++;
               $display("FAIL rnd_err[%0d] cyc %0d got %b exp %b", i, n, act_err[i], merr[i]);
            end
         end
      end
      softreset = 1'b0;
      writes = 4'd0;
   endtask

   initial begin
      test_reset();
      test_single_lane();
      test_burst();
      test_backpressure();
      test_badwrite();
      test_softreset();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
